// File: rtl/frame_state_snapshot.sv
// frame_state_snapshot
// Pixel-clock divider plus a once-per-frame snapshot of packed game state.
// The renderer only ever sees state_out, which changes on a single clk edge
// per frame (or every clk in the transparent legacy mode), so a frame never
// mixes old and new positions/scores. Change flags, a frame counter, a freeze
// mode and a saturating missed-capture counter ride along with the snapshot.

module frame_state_snapshot #(
    parameter int NUM_CH    = 8,
    parameter int CH_W      = 19,
    parameter int CLK_DIV   = 2,
    parameter int SNAP_MODE = 0,
    parameter int FC_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vblank_in,
    input  logic                   freeze,
    input  logic [NUM_CH*CH_W-1:0] state_in,
    output logic [NUM_CH*CH_W-1:0] state_out,
    output logic [NUM_CH-1:0]      changed,
    output logic                   snap_pulse,
    output logic [FC_W-1:0]        frame_count,
    output logic [7:0]             missed,
    output logic                   vga_clk
);

    localparam int              SW       = NUM_CH * CH_W;
    localparam logic [7:0]      DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0]      CNT_ONE  = 8'd1;
    localparam logic [7:0]      MISS_MAX = 8'hFF;
    localparam logic [FC_W-1:0] FC_ONE   = FC_W'(1);

    // Per-channel inequality between the live state and the held snapshot.
    function automatic logic [NUM_CH-1:0] diff_channels(
        input logic [SW-1:0] live_v,
        input logic [SW-1:0] held_v
    );
        logic [NUM_CH-1:0] diff_v;
        diff_v = {NUM_CH{1'b0}};
        for (int ch = 0; ch < NUM_CH; ch++) begin
            diff_v[ch] = (live_v[ch*CH_W +: CH_W] != held_v[ch*CH_W +: CH_W]);
        end
        return diff_v;
    endfunction

    logic [7:0]        div_cnt_q,  div_cnt_d;
    logic              vga_clk_q,  vga_clk_d;
    logic              vblank_q,   vblank_d;
    logic [SW-1:0]     state_q,    state_d;
    logic [NUM_CH-1:0] changed_q,  changed_d;
    logic              snap_q,     snap_d;
    logic [FC_W-1:0]   fc_q,       fc_d;
    logic [7:0]        missed_q,   missed_d;

    logic              vb_rise_s;
    logic              cap_s;

    // Edge detect on vblank and the capture decision for the selected mode.
    always_comb begin
        vb_rise_s = vblank_in & ~vblank_q;
        cap_s     = 1'b0;
        if (SNAP_MODE != 0) begin
            cap_s = ~freeze;
        end else begin
            cap_s = vb_rise_s & ~freeze;
        end
    end

    // Next-state for divider, snapshot, flags and counters.
    always_comb begin
        div_cnt_d = div_cnt_q;
        vga_clk_d = 1'b0;
        vblank_d  = vblank_in;
        state_d   = state_q;
        changed_d = changed_q;
        snap_d    = 1'b0;
        fc_d      = fc_q;
        missed_d  = missed_q;

        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = 8'd0;
            vga_clk_d = 1'b1;
        end else begin
            div_cnt_d = div_cnt_q + CNT_ONE;
            vga_clk_d = 1'b0;
        end

        if (cap_s) begin
            state_d   = state_in;
            changed_d = diff_channels(state_in, state_q);
            snap_d    = 1'b1;
        end else begin
            snap_d    = 1'b0;
        end

        if (vb_rise_s) begin
            fc_d = fc_q + FC_ONE;
        end else begin
            fc_d = fc_q;
        end

        // A frozen vblank edge is a dropped capture; the count sticks at 255.
        if (vb_rise_s && freeze && (missed_q != MISS_MAX)) begin
            missed_d = missed_q + CNT_ONE;
        end else begin
            missed_d = missed_q;
        end
    end

    // State registers; reset wins over any capture in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= 8'd0;
            vga_clk_q <= 1'b0;
            vblank_q  <= 1'b0;
            state_q   <= {SW{1'b0}};
            changed_q <= {NUM_CH{1'b0}};
            snap_q    <= 1'b0;
            fc_q      <= {FC_W{1'b0}};
            missed_q  <= 8'd0;
        end else begin
            div_cnt_q <= div_cnt_d;
            vga_clk_q <= vga_clk_d;
            vblank_q  <= vblank_d;
            state_q   <= state_d;
            changed_q <= changed_d;
            snap_q    <= snap_d;
            fc_q      <= fc_d;
            missed_q  <= missed_d;
        end
    end

    assign state_out   = state_q;
    assign changed     = changed_q;
    assign snap_pulse  = snap_q;
    assign frame_count = fc_q;
    assign missed      = missed_q;
    assign vga_clk     = vga_clk_q;

endmodule

// File: tb/tb_frame_state_snapshot.sv
// Directed bench for frame_state_snapshot: instance a is the default
// vblank-capture build (CLK_DIV=2), instance b the transparent legacy build
// with CLK_DIV=5 and a narrow frame counter so the wrap is reachable.

module tb_frame_state_snapshot;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    // Instance a: SNAP_MODE=0, CLK_DIV=2, 8 x 19-bit channels, 16-bit counter.
    logic          rst_a, vb_a, frz_a;
    logic [151:0]  st_a, so_a;
    logic [7:0]    chg_a;
    logic          snap_a;
    logic [15:0]   fc_a;
    logic [7:0]    mis_a;
    logic          vga_a;

    // Instance b: SNAP_MODE=1, CLK_DIV=5, 2 x 7-bit channels, 4-bit counter.
    logic          rst_b, vb_b, frz_b;
    logic [13:0]   st_b, so_b;
    logic [1:0]    chg_b;
    logic          snap_b;
    logic [3:0]    fc_b;
    logic [7:0]    mis_b;
    logic          vga_b;

    frame_state_snapshot #(.NUM_CH(8), .CH_W(19), .CLK_DIV(2), .SNAP_MODE(0), .FC_W(16)) dut_a (
        .clk(clk), .rst(rst_a), .vblank_in(vb_a), .freeze(frz_a), .state_in(st_a),
        .state_out(so_a), .changed(chg_a), .snap_pulse(snap_a), .frame_count(fc_a),
        .missed(mis_a), .vga_clk(vga_a)
    );

    frame_state_snapshot #(.NUM_CH(2), .CH_W(7), .CLK_DIV(5), .SNAP_MODE(1), .FC_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .vblank_in(vb_b), .freeze(frz_b), .state_in(st_b),
        .state_out(so_b), .changed(chg_b), .snap_pulse(snap_b), .frame_count(fc_b),
        .missed(mis_b), .vga_clk(vga_b)
    );

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [63:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    // One full clock: inputs set before the posedge, outputs read at negedge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic a_edges(input int n);
        for (int k = 0; k < n; k++) begin
            vb_a = 1'b1; cyc();
            vb_a = 1'b0; cyc();
        end
    endtask

    task automatic b_edges(input int n);
        for (int k = 0; k < n; k++) begin
            vb_b = 1'b1; cyc();
            vb_b = 1'b0; cyc();
        end
    endtask

    logic [13:0] prev_b;
    logic [1:0]  chg_exp_b;

    initial begin
        rst_a = 1'b1; vb_a = 1'b0; frz_a = 1'b0; st_a = 152'd0;
        rst_b = 1'b1; vb_b = 1'b0; frz_b = 1'b0; st_b = 14'd0;
        cyc(); cyc();

        // Reset state of instance a.
        push("a_rst_state", 64'd0); push("a_rst_chg", 64'd0); push("a_rst_snap", 64'd0);
        push("a_rst_fc", 64'd0);    push("a_rst_missed", 64'd0); push("a_rst_vga", 64'd0);
        pop_check(64'(|so_a)); pop_check(64'(chg_a)); pop_check(64'(snap_a));
        pop_check(64'(fc_a));  pop_check(64'(mis_a)); pop_check(64'(vga_a));

        // Divider /2: first high on the 2nd edge after release.
        rst_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push("a_vga", (i % 2 == 1) ? 64'd1 : 64'd0);
            cyc();
            pop_check(64'(vga_a));
        end

        // First capture; later state_in change while vblank stays high is ignored.
        st_a[18:0] = 19'h00123;
        vb_a = 1'b1;
        push("a_cap1_ch0", 64'h123); push("a_cap1_chg", 64'h01);
        push("a_cap1_snap", 64'd1);  push("a_cap1_fc", 64'd1);
        cyc();
        pop_check(64'(so_a[18:0])); pop_check(64'(chg_a)); pop_check(64'(snap_a)); pop_check(64'(fc_a));
        st_a[18:0] = 19'h00456;
        for (int i = 0; i < 2; i++) begin
            push("a_hold_ch0", 64'h123); push("a_hold_snap", 64'd0); push("a_hold_chg", 64'h01);
            cyc();
            pop_check(64'(so_a[18:0])); pop_check(64'(snap_a)); pop_check(64'(chg_a));
        end
        vb_a = 1'b0; cyc();

        // Second edge: ch0 and the top channel change.
        st_a[151:133] = 19'h7FFFF;
        vb_a = 1'b1;
        push("a_cap2_ch0", 64'h456); push("a_cap2_ch7", 64'h7FFFF);
        push("a_cap2_chg", 64'h81);  push("a_cap2_fc", 64'd2);
        cyc();
        pop_check(64'(so_a[18:0])); pop_check(64'(so_a[151:133])); pop_check(64'(chg_a)); pop_check(64'(fc_a));
        vb_a = 1'b0; cyc();

        // Third edge with identical state: no change flags, still a strobe.
        vb_a = 1'b1;
        push("a_cap3_chg", 64'd0); push("a_cap3_snap", 64'd1); push("a_cap3_fc", 64'd3);
        cyc();
        pop_check(64'(chg_a)); pop_check(64'(snap_a)); pop_check(64'(fc_a));
        vb_a = 1'b0; cyc();

        // Three frozen edges.
        frz_a = 1'b1;
        st_a[18:0] = 19'h00ABC;
        for (int i = 0; i < 3; i++) begin
            vb_a = 1'b1;
            push("a_frz_snap", 64'd0);
            cyc();
            pop_check(64'(snap_a));
            vb_a = 1'b0; cyc();
        end
        push("a_frz_ch0", 64'h456); push("a_frz_missed", 64'd3); push("a_frz_fc", 64'd6);
        pop_check(64'(so_a[18:0])); pop_check(64'(mis_a)); pop_check(64'(fc_a));

        // Freeze drops while vblank is already high: wait for the next edge.
        vb_a = 1'b1; cyc();
        frz_a = 1'b0;
        push("a_late_snap", 64'd0); push("a_late_ch0", 64'h456);
        cyc();
        pop_check(64'(snap_a)); pop_check(64'(so_a[18:0]));
        vb_a = 1'b0; cyc();
        vb_a = 1'b1;
        push("a_cap4_ch0", 64'hABC); push("a_cap4_chg", 64'h01);
        push("a_cap4_snap", 64'd1);  push("a_cap4_fc", 64'd8); push("a_cap4_missed", 64'd4);
        cyc();
        pop_check(64'(so_a[18:0])); pop_check(64'(chg_a)); pop_check(64'(snap_a));
        pop_check(64'(fc_a)); pop_check(64'(mis_a));
        vb_a = 1'b0; cyc();

        // Missed counter saturation.
        frz_a = 1'b1;
        a_edges(300);
        push("a_sat_missed", 64'd255); push("a_sat_fc", 64'd308);
        pop_check(64'(mis_a)); pop_check(64'(fc_a));

        // Reset coinciding with a capturable vblank edge.
        frz_a = 1'b0; vb_a = 1'b1; rst_a = 1'b1;
        push("a_rst2_state", 64'd0); push("a_rst2_snap", 64'd0);
        push("a_rst2_fc", 64'd0);    push("a_rst2_missed", 64'd0);
        cyc();
        pop_check(64'(|so_a)); pop_check(64'(snap_a)); pop_check(64'(fc_a)); pop_check(64'(mis_a));
        rst_a = 1'b0; vb_a = 1'b0;

        // Instance b: transparent copy and /5 divider.
        push("b_rst_state", 64'd0); push("b_rst_snap", 64'd0);
        pop_check(64'(so_b)); pop_check(64'(snap_b));
        rst_b = 1'b0;
        prev_b = 14'd0;
        for (int i = 0; i < 10; i++) begin
            st_b = {7'(i * 3 + 1), 7'(i * 5 + 2)};
            chg_exp_b = {st_b[13:7] != prev_b[13:7], st_b[6:0] != prev_b[6:0]};
            push("b_follow", 64'(st_b)); push("b_chg", 64'(chg_exp_b));
            push("b_snap", 64'd1);       push("b_vga", (i % 5 == 4) ? 64'd1 : 64'd0);
            cyc();
            pop_check(64'(so_b)); pop_check(64'(chg_b)); pop_check(64'(snap_b)); pop_check(64'(vga_b));
            prev_b = st_b;
        end

        // Freeze holds the copy; a frozen vblank edge is counted as missed.
        frz_b = 1'b1;
        st_b = 14'h3FFF;
        push("b_frz_state", 64'(prev_b)); push("b_frz_snap", 64'd0);
        cyc();
        pop_check(64'(so_b)); pop_check(64'(snap_b));
        vb_b = 1'b1;
        push("b_frz_missed", 64'd1); push("b_frz_fc", 64'd1); push("b_frz_state2", 64'(prev_b));
        cyc();
        pop_check(64'(mis_b)); pop_check(64'(fc_b)); pop_check(64'(so_b));
        vb_b = 1'b0; cyc();

        // Frame counter wrap without reset.
        frz_b = 1'b0;
        b_edges(14);
        push("b_fc_max", 64'd15); push("b_missed_keep", 64'd1);
        pop_check(64'(fc_b)); pop_check(64'(mis_b));
        vb_b = 1'b1;
        push("b_fc_wrap", 64'd0);
        cyc();
        pop_check(64'(fc_b));
        vb_b = 1'b0; cyc();

        // Reset on the edge that would wrap again.
        b_edges(15);
        push("b_fc_max2", 64'd15);
        pop_check(64'(fc_b));
        vb_b = 1'b1; rst_b = 1'b1; st_b = 14'h1234;
        push("b_rst_state2", 64'd0); push("b_rst_chg2", 64'd0); push("b_rst_snap2", 64'd0);
        push("b_rst_fc2", 64'd0);    push("b_rst_missed2", 64'd0); push("b_rst_vga2", 64'd0);
        cyc();
        pop_check(64'(so_b)); pop_check(64'(chg_b)); pop_check(64'(snap_b));
        pop_check(64'(fc_b)); pop_check(64'(mis_b)); pop_check(64'(vga_b));

        if (sb_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
